seq_transport: RTL and testbench

Transport and step scheduler for the Tang Nano step sequencer. It turns raw play and tempo push-buttons into a debounced play/stop state machine, a programmable-tempo step clock and a wrapping step index. The pattern store, LED matrix scan and tone mixer read the current step from here. This block replaces the fixed high-counter-bit step selection with controlled start/stop, adjustable tempo and a loop length.

---
 rtl/seq_pkg.sv | 28 ++
 rtl/seq_transport_if.sv | 26 ++
 rtl/seq_transport_btn_debounce.sv | 52 +++++
 rtl/seq_transport.sv | 145 ++++++++++++++
 tb/tb_seq_transport.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the step-sequencer transport.
// Holds the transport FSM states, bus widths and the tempo-to-period mapping.
package seq_pkg;

  localparam int STEP_W  = 4;
  localparam int TEMPO_W = 4;
  localparam int CNT_W   = 32;

  localparam logic [TEMPO_W-1:0] TEMPO_RST = 4'd8;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    ARM  = 2'd1,
    PLAY = 2'd2
  } seq_state_e;

  // Nominal step length in clk cycles; tempo 15 is the fastest setting.
  function automatic logic [CNT_W-1:0] step_period(
    input logic [TEMPO_W-1:0] tempo,
    input logic [CNT_W-1:0]   pmin,
    input logic [CNT_W-1:0]   pstep
  );
    logic [CNT_W-1:0] slow;
    slow = CNT_W'(4'd15 - tempo);
    return pmin + slow * pstep;
  endfunction

endpackage

// File: rtl/seq_transport_if.sv
// Button inputs, loop length and step/tempo outputs of the sequencer transport.
// The master side drives the raw buttons and loop length; the slave is the transport.
interface seq_transport_if;
  import seq_pkg::*;

  logic               play_btn;
  logic               tempo_up_btn;
  logic               tempo_dn_btn;
  logic [STEP_W-1:0]  loop_len;
  logic [STEP_W-1:0]  step;
  logic               step_tick;
  logic               playing;
  logic [TEMPO_W-1:0] tempo;
  logic               gate;

  modport master (
    output play_btn, tempo_up_btn, tempo_dn_btn, loop_len,
    input  step, step_tick, playing, tempo, gate
  );

  modport slave (
    input  play_btn, tempo_up_btn, tempo_dn_btn, loop_len,
    output step, step_tick, playing, tempo, gate
  );

endinterface

// File: rtl/seq_transport_btn_debounce.sv
// Debouncer for one raw active-low push-button: 2-flop synchronizer plus stability count.
// Emits a one-cycle press pulse when the debounced level falls.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A level is accepted only once the synchronized input has differed for DEBOUNCE_CYC+1 samples.
  always_comb begin
    db_d    = db_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC)) begin
        db_d    = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/seq_transport.sv
// Transport and step scheduler: debounced play/stop FSM, tempo register and step clock.
// Build option SEQ_SWING_EN lengthens even steps and shortens odd steps by period/4.
//
// state | meaning
// STOP  | idle, step held at 0, gate low
// ARM   | single cycle after a play press; step 0 and first tick visible
// PLAY  | counter runs down; each expiry advances (or wraps) the step
module seq_transport
  import seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 270000,
  parameter int unsigned PERIOD_MIN   = 4194304,
  parameter int unsigned PERIOD_STEP  = 524288
) (
  input logic            clk,
  input logic            rst,
  seq_transport_if.slave bus
);

  logic play_p, up_p, dn_p;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_play (
    .clk(clk), .rst(rst), .btn_raw(bus.play_btn), .press(play_p)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_up (
    .clk(clk), .rst(rst), .btn_raw(bus.tempo_up_btn), .press(up_p)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dn (
    .clk(clk), .rst(rst), .btn_raw(bus.tempo_dn_btn), .press(dn_p)
  );

  seq_state_e         state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d, step_nxt;
  logic [TEMPO_W-1:0] tempo_q, tempo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   per_cur_q, per_cur_d;
  logic [CNT_W-1:0]   period, load_len;
  logic               tick_q, tick_d;
  logic               playing_q, playing_d;
  logic               gate_q, gate_d;

  always_comb begin
    tempo_d = tempo_q;
    if (up_p && !dn_p && tempo_q != 4'd15) begin
      tempo_d = tempo_q + TEMPO_W'(1);
    end else if (dn_p && !up_p && tempo_q != 4'd0) begin
      tempo_d = tempo_q - TEMPO_W'(1);
    end
  end

`ifdef SEQ_SWING_EN
  logic load_odd;
`endif

  always_comb begin
    period   = step_period(tempo_q, CNT_W'(PERIOD_MIN), CNT_W'(PERIOD_STEP));
    step_nxt = (step_q >= bus.loop_len) ? '0 : step_q + STEP_W'(1);
`ifdef SEQ_SWING_EN
    // Parity of the step being loaded: ARM always loads step 0.
    load_odd = (state_q != STOP) && step_nxt[0];
    load_len = load_odd ? period - (period >> 2) : period + (period >> 2);
`else
    load_len = period;
`endif
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    per_cur_d = per_cur_q;
    tick_d    = 1'b0;
    playing_d = playing_q;
    case (state_q)
      STOP: begin
        step_d    = '0;
        cnt_d     = '0;
        playing_d = 1'b0;
        if (play_p) begin
          state_d   = ARM;
          tick_d    = 1'b1;
          playing_d = 1'b1;
          per_cur_d = load_len;
          cnt_d     = load_len - CNT_W'(1);
        end
      end
      ARM: begin
        state_d = PLAY;
        cnt_d   = cnt_q - CNT_W'(1);
      end
      PLAY: begin
        // A stop press outranks an advance falling in the same cycle.
        if (play_p) begin
          state_d   = STOP;
          step_d    = '0;
          cnt_d     = '0;
          playing_d = 1'b0;
        end else if (cnt_q == '0) begin
          step_d    = step_nxt;
          tick_d    = 1'b1;
          per_cur_d = load_len;
          cnt_d     = load_len - CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d   = STOP;
        step_d    = '0;
        cnt_d     = '0;
        playing_d = 1'b0;
      end
    endcase
    gate_d = playing_d && (cnt_d >= (per_cur_d >> 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= STOP;
      step_q    <= '0;
      tempo_q   <= TEMPO_RST;
      cnt_q     <= '0;
      per_cur_q <= '0;
      tick_q    <= 1'b0;
      playing_q <= 1'b0;
      gate_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      tempo_q   <= tempo_d;
      cnt_q     <= cnt_d;
      per_cur_q <= per_cur_d;
      tick_q    <= tick_d;
      playing_q <= playing_d;
      gate_q    <= gate_d;
    end
  end

  assign bus.step      = step_q;
  assign bus.step_tick = tick_q;
  assign bus.playing   = playing_q;
  assign bus.tempo     = tempo_q;
  assign bus.gate      = gate_q;

endmodule

// File: tb/tb_seq_transport.sv
// Self-checking bench for seq_transport with short debounce and period constants.
// Tick spacing, step order, gate width and tempo are predicted from the period formula.
module tb_seq_transport;
  import seq_pkg::*;

  localparam int D     = 4;
  localparam int PMIN  = 16;
  localparam int PSTEP = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  seq_transport_if bus();

  seq_transport #(
    .DEBOUNCE_CYC(D), .PERIOD_MIN(PMIN), .PERIOD_STEP(PSTEP)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_step, m_len, m_tempo, since, gate_cnt, hold;
  int seen[$];

  typedef struct {
    bit up;
    bit dn;
    int reps;
    int exp_tempo;
  } tvec_t;

  tvec_t tv[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int period_of(input int t);
    return PMIN + (15 - t) * PSTEP;
  endfunction

  function automatic int len_of(input int s, input int t);
    int p;
    p = period_of(t);
`ifdef SEQ_SWING_EN
    return (s % 2 == 0) ? p + p / 4 : p - p / 4;
`else
    return p;
`endif
  endfunction

  task automatic start_play(input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    bus.play_btn = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.step_tick) begin
        lat = i;
        break;
      end
    end
    bus.play_btn = 1'b1;
    chk({tag, " arm latency"}, lat, D + 4);
    chk({tag, " arm step"}, int'(bus.step), 0);
    chk({tag, " playing"}, int'(bus.playing), 1);
    m_step   = 0;
    m_len    = len_of(0, m_tempo);
    since    = 0;
    gate_cnt = int'(bus.gate);
    seen.delete();
    seen.push_back(int'(bus.step));
  endtask

  // Follows n step ticks; each tick is checked against the model's step, spacing and gate width.
  task automatic run_play(input int n, input bit rnd);
    int got, budget, exp_step;
    got    = 0;
    budget = n * 200 + 50;
    while (got < n && budget > 0) begin
      @(negedge clk);
      budget--;
      since++;
      if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          bus.tempo_up_btn = 1'b1;
          bus.tempo_dn_btn = 1'b1;
        end
      end
      if (bus.step_tick) begin
        got++;
        exp_step = (m_step >= int'(bus.loop_len)) ? 0 : m_step + 1;
        chk("step value", int'(bus.step), exp_step);
        chk("tick spacing", since, m_len);
        chk("gate width", gate_cnt, m_len - m_len / 2);
        chk("tempo", int'(bus.tempo), m_tempo);
        m_step = exp_step;
        seen.push_back(int'(bus.step));
        m_len    = len_of(m_step, m_tempo);
        since    = 0;
        gate_cnt = int'(bus.gate);
        if (rnd && got < n) begin
          if (got % 2 == 0 && hold == 0) begin
            case ($urandom_range(0, 3))
              0: begin
                bus.tempo_up_btn = 1'b0;
                hold = 8;
                if (m_tempo < 15) m_tempo++;
              end
              1: begin
                bus.tempo_dn_btn = 1'b0;
                hold = 8;
                if (m_tempo > 0) m_tempo--;
              end
              2: begin
                bus.tempo_up_btn = 1'b0;
                bus.tempo_dn_btn = 1'b0;
                hold = 8;
              end
              default: ;
            endcase
          end
          if ($urandom_range(0, 3) == 0) bus.loop_len = 4'($urandom_range(0, 15));
        end
      end else begin
        gate_cnt += int'(bus.gate);
      end
    end
    if (got < n) chk("tick timeout", got, n);
  endtask

  initial begin
    int lat, ticks;
    int exp_seq[6];
    exp_seq = '{0, 1, 2, 3, 0, 1};
    tv[0] = '{1'b1, 1'b0, 2, 10};
    tv[1] = '{1'b0, 1'b1, 16, 0};
    tv[2] = '{1'b1, 1'b1, 1, 0};
    tv[3] = '{1'b1, 1'b0, 20, 15};
    tv[4] = '{1'b1, 1'b1, 2, 15};
    tv[5] = '{1'b0, 1'b1, 3, 12};

    bus.play_btn     = 1'b1;
    bus.tempo_up_btn = 1'b1;
    bus.tempo_dn_btn = 1'b1;
    bus.loop_len     = 4'd3;
    hold             = 0;
    m_tempo          = 8;

    repeat (3) @(negedge clk);
    chk("reset step", int'(bus.step), 0);
    chk("reset tempo", int'(bus.tempo), 8);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle step", int'(bus.step), 0);
    chk("idle tick", int'(bus.step_tick), 0);
    chk("idle playing", int'(bus.playing), 0);
    chk("idle tempo", int'(bus.tempo), 8);
    chk("idle gate", int'(bus.gate), 0);

    // Bounces shorter than the debounce window must never produce a press.
    ticks = 0;
    repeat (5) begin
      bus.play_btn = 1'b0;
      repeat (3) begin @(negedge clk); ticks += int'(bus.step_tick); end
      bus.play_btn = 1'b1;
      repeat (3) begin @(negedge clk); ticks += int'(bus.step_tick); end
    end
    repeat (20) begin @(negedge clk); ticks += int'(bus.step_tick); end
    chk("bounce playing", int'(bus.playing), 0);
    chk("bounce ticks", ticks, 0);

    bus.loop_len = 4'd3;
    start_play("start");
    run_play(5, 1'b0);
    chk("wrap seq length", seen.size(), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++) chk($sformatf("wrap seq %0d", i), seen[i], exp_seq[i]);

    bus.play_btn = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!bus.playing) begin
        lat = i;
        break;
      end
    end
    bus.play_btn = 1'b1;
    chk("stop latency", lat, D + 4);
    chk("stop step", int'(bus.step), 0);
    chk("stop gate", int'(bus.gate), 0);
    ticks = 0;
    repeat (100) begin @(negedge clk); ticks += int'(bus.step_tick); end
    chk("stopped ticks", ticks, 0);

    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < tv[i].reps; r++) begin
        @(negedge clk);
        bus.tempo_up_btn = !tv[i].up;
        bus.tempo_dn_btn = !tv[i].dn;
        repeat (8) @(negedge clk);
        bus.tempo_up_btn = 1'b1;
        bus.tempo_dn_btn = 1'b1;
        repeat (10) @(negedge clk);
      end
      chk($sformatf("tempo vec %0d", i), int'(bus.tempo), tv[i].exp_tempo);
    end
    m_tempo = 12;

    bus.loop_len = 4'd15;
    start_play("restart");
    run_play(40, 1'b1);

    bus.loop_len = 4'd7;
    for (int k = 0; k < 20 && m_step != 5; k++) run_play(1, 1'b0);
    chk("reach step 5", m_step, 5);
    bus.loop_len = 4'd2;
    run_play(1, 1'b0);
    chk("shrink wrap", int'(bus.step), 0);

    // Time the press so its pulse lands in the same cycle as the next advance.
    repeat (m_len - 8) @(negedge clk);
    bus.play_btn = 1'b0;
    ticks = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      ticks += int'(bus.step_tick);
      if (i == 12) bus.play_btn = 1'b1;
    end
    chk("coincide ticks", ticks, 0);
    chk("coincide playing", int'(bus.playing), 0);
    chk("coincide step", int'(bus.step), 0);
    chk("coincide gate", int'(bus.gate), 0);

    bus.loop_len = 4'd3;
    start_play("reset run");
    for (int k = 0; k < 10 && m_step != 2; k++) run_play(1, 1'b0);
    chk("reach step 2", int'(bus.step), 2);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async rst step", int'(bus.step), 0);
    chk("async rst playing", int'(bus.playing), 0);
    chk("async rst gate", int'(bus.gate), 0);
    chk("async rst tempo", int'(bus.tempo), 8);
    chk("async rst tick", int'(bus.step_tick), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("post rst playing", int'(bus.playing), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
